// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   reg_addr_e : register word addresses (addr[3:2])
//   CTRL_*     : CTRL register field positions, writable mask and reset value
//   SEG_LUT    : hex -> segment a..g encodings (active-high, bit6=a .. bit0=g)
//   be_merge   : byte-enable write merge helper
package seg7_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_STATUS = 2'd2,
    REG_NONE   = 2'd3
  } reg_addr_e;

  localparam int CTRL_BLANK_LSB = 0;
  localparam int CTRL_DP_LSB    = 8;
  localparam int CTRL_BRT_LSB   = 16;
  localparam int CTRL_EN_BIT    = 31;

  // Only blank, dp, brightness and enable exist; everything else reads 0.
  localparam logic [31:0] CTRL_MASK  = 32'h800F_FFFF;
  localparam logic [31:0] CTRL_RESET = 32'h800F_0000;

  // Index 15 first so SEG_LUT[h] gives the pattern for hex digit h.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return (old_v & ~m) | (new_v & m);
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Register bus between a host and the scan controller.
//   addr  : word address (0=DATA, 1=CTRL, 2=STATUS, 3=unmapped)
//   we    : write strobe, sampled every clock
//   be    : byte enables for the write
//   wdata : write data
//   rdata : combinational readback of the register selected by addr
interface seg7_scan_ctrl_if;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output be, output wdata, input rdata);
  modport slave  (input addr, input we, input be, input wdata, output rdata);
endinterface

// File: rtl/seg7_decoder.sv
// Combinational hex to 7-segment decoder.
//   i_hex : 4-bit hex value
//   o_seg : segments a..g (bit6=a .. bit0=g), active-high, no dp
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_LUT[i_hex];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment display scanner with a small register file.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : register bus (slave side), DATA / CTRL / STATUS
//   sel         : one-hot digit select, registered
//   seg         : {dp, a..g}, registered
//   frame_tick  : one-cycle pulse after each full scan of all digits
// ACTIVE_LOW inverts sel/seg at the pins, so inactive is all-ones there.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_CYCLES = 20000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_scan_ctrl_if.slave       bus,
  output logic [NUM_DIGITS-1:0] sel,
  output logic [7:0]            seg,
  output logic                  frame_tick
);

  localparam int SW = $clog2(SCAN_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);
  // Nibbles of non-existent digits are tied to 0.
  localparam logic [31:0] DATA_MASK = (NUM_DIGITS >= 8) ? 32'hFFFF_FFFF
                                    : 32'((64'd1 << (4 * NUM_DIGITS)) - 64'd1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [31:0]           r_data, r_ctrl;
  logic [SW-1:0]         r_slot;
  logic [2:0]            r_idx;
  logic [3:0]            r_pwm;
  logic [15:0]           r_frame;
  logic                  r_frame_tick;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_sel;

  reg_addr_e             w_addr;
  logic                  w_en, w_slot_wrap, w_idx_wrap, w_lit;
  logic [7:0]            w_blank_mask, w_dp_mask;
  logic [3:0]            w_bright, w_hex;
  logic [6:0]            w_seg7;

  assign w_addr       = reg_addr_e'(bus.addr);
  assign w_en         = r_ctrl[CTRL_EN_BIT];
  assign w_blank_mask = r_ctrl[CTRL_BLANK_LSB +: 8];
  assign w_dp_mask    = r_ctrl[CTRL_DP_LSB +: 8];
  assign w_bright     = r_ctrl[CTRL_BRT_LSB +: 4];
  assign w_slot_wrap  = (r_slot == SLOT_LAST);
  assign w_idx_wrap   = w_slot_wrap && (r_idx == IDX_LAST);

  // Register writes; unmapped and STATUS writes fall through.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_ctrl <= CTRL_RESET;
    end else if (bus.we) begin
      case (w_addr)
        REG_DATA: r_data <= be_merge(r_data, bus.wdata, bus.be) & DATA_MASK;
        REG_CTRL: r_ctrl <= be_merge(r_ctrl, bus.wdata, bus.be) & CTRL_MASK;
        default:  ;
      endcase
    end
  end

  // Scan counters are parked at 0 while disabled so a re-enable starts
  // cleanly at digit 0, slot 0, PWM phase 0.
  always_ff @(posedge clk) begin
    if (reset || !w_en) begin
      r_slot <= '0;
      r_idx  <= '0;
      r_pwm  <= '0;
    end else begin
      r_pwm <= r_pwm + 4'd1;
      if (w_slot_wrap) begin
        r_slot <= '0;
        r_idx  <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_slot <= r_slot + SW'(1);
      end
    end
  end

  // Frame counter keeps its value across disable; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame      <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_en && w_idx_wrap;
      if (w_en && w_idx_wrap) r_frame <= r_frame + 16'd1;
    end
  end

  assign w_hex = 4'(r_data >> {r_idx, 2'b00});

  seg7_decoder u_dec (
    .i_hex (w_hex),
    .o_seg (w_seg7)
  );

  // PWM: pwm <= brightness is the same as pwm < brightness+1 without overflow.
  assign w_lit = w_en && !w_blank_mask[r_idx] && (r_pwm <= w_bright);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg <= {8{INV}};
      r_sel <= {NUM_DIGITS{INV}};
    end else begin
      r_seg <= (w_lit ? {w_dp_mask[r_idx], w_seg7} : 8'h00) ^ {8{INV}};
      r_sel <= (w_lit ? (SEL_ONE << r_idx) : '0) ^ {NUM_DIGITS{INV}};
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (w_addr)
      REG_DATA:   bus.rdata = r_data;
      REG_CTRL:   bus.rdata = r_ctrl;
      REG_STATUS: bus.rdata = {r_frame, 13'd0, r_idx};
      default:    bus.rdata = '0;
    endcase
  end

  assign seg        = r_seg;
  assign sel        = r_sel;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 4-cycle slots, active-high pins.
module tb_seg7_scan_ctrl;
  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [ND-1:0] sel;
  logic [7:0]    seg;
  logic          frame_tick;

  seg7_scan_ctrl_if bus();

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_CYCLES(SC), .ACTIVE_LOW(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .sel        (sel),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [6:0] lut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Data during display checks is 0x3210, so digit d shows hex value d.
  task automatic chk_disp(input string tag, input int d, input bit lit, input bit dp);
    logic [3:0] es;
    logic [7:0] eg;
    es = lit ? 4'(1 << d) : 4'd0;
    eg = lit ? {dp, lut[d]} : 8'h00;
    check({tag, "_sel"}, 32'(sel), 32'(es));
    check({tag, "_seg"}, 32'(seg), 32'(eg));
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.addr  = a;
    bus.we    = 1'b1;
    bus.be    = be;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.we   = 1'b0;
    bus.addr = 2'd0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    bus.addr = a;
    #1;
    check(tag, bus.rdata, exp);
    bus.addr = 2'd0;
  endtask

  // Disable then enable: after this returns, the m-th following tick shows count m-1.
  task automatic restart(input logic [31:0] ctrl);
    wr(2'd1, 4'hF, ctrl & 32'h7FFF_FFFF);
    wr(2'd1, 4'hF, ctrl);
  endtask

  initial begin
    int c;
    reset     = 1'b1;
    bus.addr  = 2'd0;
    bus.we    = 1'b0;
    bus.be    = 4'h0;
    bus.wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_ft", 32'(frame_tick), 32'h0);
    rd(2'd0, 32'h0000_0000, "rst_data");
    rd(2'd1, 32'h800F_0000, "rst_ctrl");
    rd(2'd2, 32'h0000_0000, "rst_status");
    reset = 1'b0;

    // Basic scan: digit changes every 4 cycles, frame tick every 16
    wr(2'd0, 4'hF, 32'h0000_3210);
    for (int n = 0; n < 32; n++) begin
      if (n > 0) tick();
      chk_disp($sformatf("scan_n%0d", n), (n / 4) % 4, 1'b1, 1'b0);
      check($sformatf("scan_ft_n%0d", n), 32'(frame_tick), 32'((n % 16) == 15));
    end
    rd(2'd2, 32'h0002_0000, "status_after_2_frames");

    // Byte enables and unused bits
    wr(2'd0, 4'b0001, 32'hFFFF_FFFF);
    rd(2'd0, 32'h0000_32FF, "data_be0");
    wr(2'd0, 4'hF, 32'hFFFF_FFFF);
    rd(2'd0, 32'h0000_FFFF, "data_upper_ignored");
    wr(2'd0, 4'hF, 32'h0000_3210);
    wr(2'd1, 4'hF, 32'hFFFF_FFFF);
    rd(2'd1, 32'h800F_FFFF, "ctrl_mask");
    wr(2'd1, 4'b0100, 32'h00AB_0000);
    rd(2'd1, 32'h800B_FFFF, "ctrl_be2");
    wr(2'd3, 4'hF, 32'hFFFF_FFFF);
    rd(2'd3, 32'h0000_0000, "addr3_reads0");
    rd(2'd0, 32'h0000_3210, "addr3_write_ignored");

    // Blank digit 1, decimal point on digit 0
    restart(32'h800F_0102);
    for (int m = 1; m <= 32; m++) begin
      tick();
      c = m - 1;
      chk_disp($sformatf("blank_m%0d", m), (c / 4) % 4, ((c / 4) % 4) != 1, ((c / 4) % 4) == 0);
    end

    // Brightness 3: lit while pwm (free-running from restart) is 0..3
    restart(32'h8003_0000);
    for (int m = 1; m <= 32; m++) begin
      tick();
      c = m - 1;
      chk_disp($sformatf("brt3_m%0d", m), (c / 4) % 4, (c % 16) <= 3, 1'b0);
    end

    // Brightness 0: lit only at pwm 0
    restart(32'h8000_0000);
    for (int m = 1; m <= 16; m++) begin
      tick();
      c = m - 1;
      chk_disp($sformatf("brt0_m%0d", m), (c / 4) % 4, (c % 16) == 0, 1'b0);
    end

    // Disable mid-slot, then re-enable
    restart(32'h800F_0000);
    for (int m = 1; m <= 6; m++) begin
      tick();
      c = m - 1;
      chk_disp($sformatf("pre_dis_m%0d", m), (c / 4) % 4, 1'b1, 1'b0);
    end
    wr(2'd1, 4'hF, 32'h000F_0000);
    tick();
    chk_disp("dis_1", 0, 1'b0, 1'b0);
    bus.addr = 2'd2;
    #1;
    check("dis_status_idx", 32'(bus.rdata[2:0]), 32'h0);
    bus.addr = 2'd0;
    tick();
    chk_disp("dis_2", 0, 1'b0, 1'b0);
    wr(2'd1, 4'hF, 32'h800F_0000);
    chk_disp("reen_0", 0, 1'b0, 1'b0);
    tick();
    chk_disp("reen_1", 0, 1'b1, 1'b0);
    bus.addr = 2'd2;
    #1;
    check("reen_status_idx", 32'(bus.rdata[2:0]), 32'h0);
    bus.addr = 2'd0;
    repeat (4) tick();
    chk_disp("reen_5", 1, 1'b1, 1'b0);

    // Reset during digit 2 (count 9 shown at m=10)
    repeat (5) tick();
    chk_disp("pre_rst_d2", 2, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    chk_disp("midrst", 0, 1'b0, 1'b0);
    check("midrst_ft", 32'(frame_tick), 32'h0);
    rd(2'd2, 32'h0000_0000, "midrst_status");
    rd(2'd0, 32'h0000_0000, "midrst_data");
    rd(2'd1, 32'h800F_0000, "midrst_ctrl");
    reset = 1'b0;
    tick();
    chk_disp("postrst_1", 0, 1'b1, 1'b0);
    check("postrst_seg_zero", 32'(seg), 32'h7E);
    tick();
    chk_disp("postrst_2", 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
